// File: rtl/alu_add_arbiter.sv
// Round-robin arbiter sharing one carry look-ahead adder/subtractor between two requesters.
// Optional signed-overflow output rsp_ovf is enabled by defining ALU_ADD_ARB_OVF_EN.

module cla #(
    parameter int unsigned DATA_WDTH = 32
) (
    input  logic [DATA_WDTH-1:0] a,
    input  logic [DATA_WDTH-1:0] b,
    input  logic                 en,
    output logic [DATA_WDTH-1:0] sum,
    output logic                 carry
);

    logic [DATA_WDTH-1:0] b_eff;
    logic [DATA_WDTH-1:0] p0;
    logic [DATA_WDTH-1:0] g0;
    logic [DATA_WDTH-1:0] gg;
    logic [DATA_WDTH-1:0] pp;
    logic [DATA_WDTH-1:0] gn;
    logic [DATA_WDTH-1:0] pn;
    logic [DATA_WDTH:0]   c;

    // Parallel-prefix carry tree; carry-in (en) is folded into bit 0's generate.
    always_comb begin
        b_eff = en ? ~b : b;
        p0    = a ^ b_eff;
        g0    = a & b_eff;
        g0[0] = g0[0] | (p0[0] & en);
        gg    = g0;
        pp    = p0;
        gn    = g0;
        pn    = p0;
        for (int unsigned d = 1; d < DATA_WDTH; d = d * 2) begin
            gn = gg;
            pn = pp;
            for (int unsigned i = d; i < DATA_WDTH; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i-d]);
                pn[i] = pp[i] & pp[i-d];
            end
            gg = gn;
            pp = pn;
        end
        c     = {gg, en};
        sum   = p0 ^ c[DATA_WDTH-1:0];
        carry = c[DATA_WDTH];
    end

endmodule

module alu_add_arbiter #(
    parameter int unsigned DATA_WDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATA_WDTH-1:0] req0_a,
    input  logic [DATA_WDTH-1:0] req0_b,
    input  logic                 req0_sub,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATA_WDTH-1:0] req1_a,
    input  logic [DATA_WDTH-1:0] req1_b,
    input  logic                 req1_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [DATA_WDTH-1:0] rsp_sum,
    output logic                 rsp_carry,
`ifdef ALU_ADD_ARB_OVF_EN
    output logic                 rsp_ovf,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 rr_last_q;
    logic [DATA_WDTH-1:0] op_a_q;
    logic [DATA_WDTH-1:0] op_b_q;
    logic                 op_sub_q;
    logic                 op_id_q;
    logic                 grant0;
    logic                 grant1;
    logic [DATA_WDTH-1:0] cla_sum;
    logic                 cla_carry;

    cla #(
        .DATA_WDTH(DATA_WDTH)
    ) u_cla (
        .a    (op_a_q),
        .b    (op_b_q),
        .en   (op_sub_q),
        .sum  (cla_sum),
        .carry(cla_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant only in IDLE; on a tie the requester that did not win last time goes.
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state_q)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || rr_last_q != 1'b0);
                grant1 = req1_valid && (!req0_valid || rr_last_q != 1'b1);
                if (grant0 || grant1) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_sub_q  <= 1'b0;
            op_id_q   <= 1'b0;
        end else if (grant0) begin
            rr_last_q <= 1'b0;
            op_a_q    <= req0_a;
            op_b_q    <= req0_b;
            op_sub_q  <= req0_sub;
            op_id_q   <= 1'b0;
        end else if (grant1) begin
            rr_last_q <= 1'b1;
            op_a_q    <= req1_a;
            op_b_q    <= req1_b;
            op_sub_q  <= req1_sub;
            op_id_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id_q;
            rsp_sum   <= cla_sum;
            rsp_carry <= cla_carry;
        end else if (state_q == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ADD_ARB_OVF_EN
    logic b_eff_msb;

    assign b_eff_msb = op_b_q[DATA_WDTH-1] ^ op_sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ovf <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_ovf <= (op_a_q[DATA_WDTH-1] == b_eff_msb) &&
                       (cla_sum[DATA_WDTH-1] != op_a_q[DATA_WDTH-1]);
        end
    end
`endif

endmodule
